// File: rtl/mips_pkg.sv
// Shared types and encodings for the fetch stage and the main/ALU decoders.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } fetch_state_t;

    // 2'b11 is not a member; consumers treat it like J_SEQ.
    typedef enum logic [1:0] {
        J_SEQ = 2'b00,
        J_JMP = 2'b01,
        J_JR  = 2'b10
    } jump_sel_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC select (JR > J/JAL > taken branch > sequential) plus JR
// misalignment detect.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] pcplus4,
    input  logic [25:0]   instr_index,
    input  logic          pcsrc,
    input  logic [1:0]    jump,
    input  logic [AW-1:0] jr_target,
    output logic [AW-1:0] next_pc,
    output logic          addr_err
);

    logic [AW-1:0] br_offset;
    logic [AW-1:0] jmp_target;

    always_comb begin
        br_offset  = {{(AW-18){instr_index[15]}}, instr_index[15:0], 2'b00};
        // J/JAL keeps the 256 MB region of the delay-slot address.
        jmp_target        = pcplus4;
        jmp_target[27:0]  = {instr_index, 2'b00};

        next_pc  = pcplus4;
        addr_err = 1'b0;
        case (jump)
            J_JR: begin
                next_pc  = {jr_target[AW-1:2], 2'b00};
                addr_err = |jr_target[1:0];
            end
            J_JMP:   next_pc = jmp_target;
            default: if (pcsrc) next_pc = pcplus4 + br_offset;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack imem port, held instruction for decode.
// Optional performance counters under FETCH_PERF_CNT_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pcplus4,
    input  logic          pcsrc,
    input  logic [1:0]    jump,
    input  logic [AW-1:0] jr_target,
    output logic          addr_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          addr_err_q, addr_err_d;
    logic [AW-1:0] next_pc;
    logic          jr_misaligned;
    logic          consume;
    logic          stall;

    pc_next_sel #(
        .AW (AW)
    ) u_pc_next_sel (
        .pcplus4     (pcplus4),
        .instr_index (instr_q[25:0]),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .jr_target   (jr_target),
        .next_pc     (next_pc),
        .addr_err    (jr_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        addr_err_d  = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        consume     = 1'b0;
        stall       = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end else begin
                    stall = 1'b1;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    consume    = 1'b1;
                    pc_d       = next_pc;
                    addr_err_d = jr_misaligned;
                    state_d    = REQ;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pcplus4   = pc_q + AW'(4);
    assign instr     = instr_q;
    assign addr_err  = addr_err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (consume) fetched_q <= fetched_q + 32'd1;
            if (stall)   stall_q   <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`else
    logic unused_perf;
    assign unused_perf = consume ^ stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level next-PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pcsrc;
    logic [1:0]  jump;
    logic [31:0] jr_target;
    logic        addr_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .jr_target   (jr_target),
        .addr_err    (addr_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference next-PC, written straight from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic br, input logic [1:0] jsel,
                                               input logic [31:0] jr);
        logic [31:0] seq;
        logic [31:0] tgt;
        seq = cur + 32'd4;
        if (jsel == 2'b10) return jr & 32'hFFFF_FFFC;
        if (jsel == 2'b01) begin
            tgt = (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
            return tgt;
        end
        if (br) return seq + 32'($signed(word[15:0])) * 32'd4;
        return seq;
    endfunction

    task automatic idle_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 2'b00;
        jr_target   = '0;
    endtask

    // Leaves the bench at a negedge with reset just released (DUT still idle).
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset    = 1'b1;
        imem_ack = 1'b1;  // stale ack must not advance the FSM
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 ||
            addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h err=%b required 0/0/0/0/0",
                     imem_req, instr_valid, instr, pc, addr_err);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
            errors++;
            $display("FAIL reset_perf: fetched=%0d stall=%0d required 0/0", perf_fetched, perf_stall);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: req=%b valid=%b addr=%h required 1/0/00000000",
                     imem_req, instr_valid, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] word;
        do_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        word        = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i / 2))) begin
                    errors++;
                    $display("FAIL stream_addr[%0d]: req=%b addr=%h required 1/%h", i, imem_req,
                             imem_addr, 32'(4 * (i / 2)));
                end
                word       = $urandom;
                imem_rdata = word;
            end else begin
                checks++;
                if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word ||
                    pc !== 32'(4 * (i / 2)) || pcplus4 !== 32'(4 * (i / 2) + 4)) begin
                    errors++;
                    $display("FAIL stream_hold[%0d]: valid=%b instr=%h pc=%h p4=%h required 1/%h/%h/%h",
                             i, instr_valid, instr, pc, pcplus4, word, 32'(4 * (i / 2)),
                             32'(4 * (i / 2) + 4));
                end
            end
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        instr_ready = 1'b1;
        imem_rdata  = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL ack_delay_req[%0d]: req=%b addr=%h valid=%b required 1/0/0", i,
                         imem_req, imem_addr, instr_valid);
            end
            if (i == 3) imem_ack = 1'b1;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL ack_delay_capture: valid=%b instr=%h required 1/cafe0001", instr_valid,
                     instr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_stall !== 32'd3) begin
            errors++;
            $display("FAIL ack_delay_stall: stall=%0d required 3", perf_stall);
        end
`endif
    endtask

    task automatic test_hold_stall();
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);  // REQ
        @(negedge clk);  // HOLD
        imem_ack = 1'b0;
        pcsrc    = 1'b1;
        jump     = 2'b10;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h1234_5678 ||
                pc !== 32'h0) begin
                errors++;
                $display("FAIL hold_stall[%0d]: valid=%b req=%b instr=%h pc=%h required 1/0/12345678/0",
                         i, instr_valid, imem_req, instr, pc);
            end
            @(negedge clk);
        end
        pcsrc       = 1'b0;
        jump        = 2'b00;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL hold_release: req=%b addr=%h required 1/00000004", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirects();
        logic [31:0] words[9]  = '{32'h0800_0010, 32'h1000_FFFE, 32'h0800_0010, 32'hDEAD_BEEF,
                                   32'h1000_0004, 32'h1000_0004, 32'h0123_4567, 32'h0000_0000,
                                   32'h0BFF_FFFF};
        logic        brs[9]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  jumps[9]  = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01};
        logic [31:0] jrs[9]    = '{32'h0, 32'h0, 32'h0, 32'h103, 32'h0, 32'h0, 32'hFFFF_FFFC,
                                   32'h0, 32'h0};
        logic [31:0] at[10]    = '{32'h0, 32'h40, 32'h3C, 32'h40, 32'h100, 32'h104, 32'h118,
                                   32'hFFFF_FFFC, 32'h0, 32'h0FFF_FFFC};
        logic        errs[9]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== at[i]) begin
                errors++;
                $display("FAIL redirect_fetch[%0d]: req=%b addr=%h required 1/%h", i, imem_req,
                         imem_addr, at[i]);
            end
            imem_ack   = 1'b1;
            imem_rdata = words[i];
            @(negedge clk);
            imem_ack    = 1'b0;
            instr_ready = 1'b1;
            pcsrc       = brs[i];
            jump        = jumps[i];
            jr_target   = jrs[i];
            @(negedge clk);
            instr_ready = 1'b0;
            pcsrc       = 1'b0;
            jump        = 2'b00;
            jr_target   = '0;
            checks++;
            if (addr_err !== errs[i]) begin
                errors++;
                $display("FAIL redirect_err[%0d]: addr_err=%b required %b", i, addr_err, errs[i]);
            end
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== at[9]) begin
            errors++;
            $display("FAIL redirect_final: req=%b addr=%h required 1/%h", imem_req, imem_addr, at[9]);
        end
        @(negedge clk);
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL redirect_err_pulse: addr_err=%b required 0", addr_err);
        end
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        repeat (5) @(negedge clk);  // now in REQ at 8
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL midreq_setup: req=%b addr=%h required 1/00000008", imem_req, imem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreq_async: req=%b pc=%h valid=%b required 0/0/0", imem_req, pc,
                     instr_valid);
        end
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b1;  // ack arriving right after release belongs to the abandoned request
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreq_restart: req=%b valid=%b addr=%h required 1/0/0", imem_req,
                     instr_valid, imem_addr);
        end
        // Reset while holding an instruction drops instr_valid without a clock.
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL midhold_setup: valid=%b required 1", instr_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL midhold_async: valid=%b instr=%h required 0/0", instr_valid, instr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] mpc;
        logic [31:0] exp_instr;
        logic        exp_err;
        logic        err_next;
        int          consumed;
        int          stalls;
        int          rnd_fail;
        do_reset();
        @(negedge clk);
        mpc       = 32'h0;
        exp_instr = 32'h0;
        exp_err   = 1'b0;
        consumed  = 0;
        stalls    = 0;
        rnd_fail  = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            err_next = 1'b0;
            checks++;
            if (addr_err !== exp_err || (imem_req === instr_valid)) begin
                errors++;
                rnd_fail++;
                if (rnd_fail < 10)
                    $display("FAIL rand_ctrl[%0d]: err=%b req=%b valid=%b required err=%b, one of req/valid",
                             cyc, addr_err, imem_req, instr_valid, exp_err);
            end
            imem_ack    = 1'($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 2) != 0);
            pcsrc       = 1'($urandom);
            jump        = 2'($urandom);
            jr_target   = $urandom;
            if (imem_req === 1'b1) begin
                checks++;
                if (imem_addr !== mpc) begin
                    errors++;
                    rnd_fail++;
                    if (rnd_fail < 10)
                        $display("FAIL rand_addr[%0d]: addr=%h required %h", cyc, imem_addr, mpc);
                end
                if (imem_ack) exp_instr = imem_rdata;
                else stalls++;
            end
            if (instr_valid === 1'b1) begin
                checks++;
                if (instr !== exp_instr || pc !== mpc || pcplus4 !== mpc + 32'd4) begin
                    errors++;
                    rnd_fail++;
                    if (rnd_fail < 10)
                        $display("FAIL rand_hold[%0d]: instr=%h pc=%h p4=%h required %h/%h/%h", cyc,
                                 instr, pc, pcplus4, exp_instr, mpc, mpc + 32'd4);
                end
                if (instr_ready) begin
                    err_next = (jump == 2'b10) && (jr_target[1:0] != 2'b00);
                    mpc      = model_next(mpc, exp_instr, pcsrc, jump, jr_target);
                    consumed++;
                end else begin
                    stalls++;
                end
            end
            exp_err = err_next;
            @(negedge clk);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'(consumed) || perf_stall !== 32'(stalls)) begin
            errors++;
            $display("FAIL rand_perf: fetched=%0d stall=%0d required %0d/%0d", perf_fetched,
                     perf_stall, consumed, stalls);
        end
`endif
        checks++;
        if (consumed < 50) begin
            errors++;
            $display("FAIL rand_progress: consumed=%0d required >=50", consumed);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_ack_delay();
        test_hold_stall();
        test_redirects();
        test_reset_mid_flight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
